// File: rtl/ip_shft_mc_if.sv
// ---------------------------------------------------------------------------
// ip_shft_mc_if
//   Bus bundle for the multi-cycle shifter ip_shft_mc.
//   Protocol: i_cal_str is a one-cycle start pulse that samples all i_*
//   operands in the same cycle. There is no ready; a start is always accepted,
//   including one that aborts a running job. The result is announced by a
//   one-cycle o_val_upd pulse. o_val_vld is a level that stays high from
//   completion until the next start. o_ovf is meaningful only while
//   o_val_vld is high.
//   master : requester side (drives i_*, reads o_*)
//   slave  : shifter side   (reads i_*, drives o_*)
//   o_dbg_state exposes the shifter FSM state (0 idle, 1 active).
// ---------------------------------------------------------------------------
interface ip_shft_mc_if #(
   parameter int IDWID = 8,
   parameter int SWID  = 4,
   parameter int ODWID = 16
);
   logic             i_cal_str;
   logic [IDWID-1:0] i_val;
   logic [SWID-1:0]  i_shft;
   logic             i_dir;
   logic             i_rnd;
   logic             i_pwr2;
   logic [ODWID-1:0] o_val;
   logic             o_val_vld;
   logic             o_val_upd;
   logic             o_ovf;
   logic             o_busy;
   logic [1:0]       o_dbg_state;

   modport master (
      output i_cal_str, i_val, i_shft, i_dir, i_rnd, i_pwr2,
      input  o_val, o_val_vld, o_val_upd, o_ovf, o_busy, o_dbg_state
   );

   modport slave (
      input  i_cal_str, i_val, i_shft, i_dir, i_rnd, i_pwr2,
      output o_val, o_val_vld, o_val_upd, o_ovf, o_busy, o_dbg_state
   );
endinterface

// File: rtl/ip_shft_mc.sv
// ---------------------------------------------------------------------------
// ip_shft_mc
//   Multi-cycle shifter: shifts an operand left or right by n bits, at most
//   STEP bits per active cycle. Right shifts can round half-up using the last
//   bit shifted out. Left shifts track lost nonzero bits and can saturate.
//   pwr2 mode forces the operand to 1, so a left shift yields 2^n.
// Ports
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : ip_shft_mc_if slave (start/operands in, result/status out)
// Parameters
//   IDWID operand width (<= ODWID), SWID shift-count width, ODWID result
//   width, STEP bits per cycle (power of 2), SAT saturate on left overflow.
// ---------------------------------------------------------------------------
module ip_shft_mc #(
   parameter int IDWID = 8,
   parameter int SWID  = 4,
   parameter int ODWID = 16,
   parameter int STEP  = 1,
   parameter int SAT   = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   ip_shft_mc_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1
   } state_e;

   // The step never needs to exceed the largest count, so clamp it to the
   // count range. min(cnt, STEP) then fits in SWID bits.
   localparam int              STEP_C = (STEP > (2**SWID - 1)) ? (2**SWID - 1) : STEP;
   localparam logic [SWID-1:0] STEP_W = SWID'(STEP_C);
   localparam logic [ODWID-1:0] ONES  = '1;

   state_e           state_q, state_d;
   logic [ODWID-1:0] work_q,  work_d;
   logic [SWID-1:0]  cnt_q,   cnt_d;
   logic             dir_q,   dir_d;
   logic             rnd_q,   rnd_d;
   logic             g_q,     g_d;
   logic             ov_q,    ov_d;
   logic [ODWID-1:0] val_q,   val_d;
   logic             vld_q,   vld_d;
   logic             upd_q,   upd_d;
   logic             ovf_q,   ovf_d;

   logic [SWID-1:0]  shamt;
   logic [ODWID-1:0] shr;

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      rnd_d   = rnd_q;
      g_d     = g_q;
      ov_d    = ov_q;
      val_d   = val_q;
      vld_d   = vld_q;
      upd_d   = 1'b0;
      ovf_d   = ovf_q;
      shamt   = '0;
      shr     = '0;

      if (bus.i_cal_str) begin
         // A start always wins, even over a job that is about to complete.
         state_d = ST_ACTIVE;
         work_d  = bus.i_pwr2 ? ODWID'(1) : ODWID'(bus.i_val);
         cnt_d   = bus.i_shft;
         dir_d   = bus.i_dir;
         rnd_d   = bus.i_rnd;
         g_d     = 1'b0;
         ov_d    = 1'b0;
         vld_d   = 1'b0;
      end else if (state_q == ST_ACTIVE) begin
         if (cnt_q != '0) begin
            shamt = (cnt_q < STEP_W) ? cnt_q : STEP_W;
            cnt_d = cnt_q - shamt;
            if (!dir_q) begin
               // The top shamt bits leave the word; any 1 among them is overflow.
               ov_d   = ov_q | (|(work_q & ~(ONES >> shamt)));
               work_d = work_q << shamt;
            end else begin
               // Keep the last bit shifted out as the rounding guard.
               shr    = work_q >> (shamt - 1'b1);
               g_d    = shr[0];
               work_d = work_q >> shamt;
            end
         end else begin
            state_d = ST_IDLE;
            upd_d   = 1'b1;
            vld_d   = 1'b1;
            ovf_d   = ~dir_q & ov_q;
            if (!dir_q && ov_q && (SAT != 0)) begin
               val_d = ONES;
            end else if (dir_q && rnd_q) begin
               // g=1 implies at least one right shift happened, so no carry-out.
               val_d = work_q + ODWID'(g_q);
            end else begin
               val_d = work_q;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         work_q  <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         rnd_q   <= 1'b0;
         g_q     <= 1'b0;
         ov_q    <= 1'b0;
         val_q   <= '0;
         vld_q   <= 1'b0;
         upd_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         rnd_q   <= rnd_d;
         g_q     <= g_d;
         ov_q    <= ov_d;
         val_q   <= val_d;
         vld_q   <= vld_d;
         upd_q   <= upd_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.o_val       = val_q;
   assign bus.o_val_vld   = vld_q;
   assign bus.o_val_upd   = upd_q;
   assign bus.o_ovf       = ovf_q;
   assign bus.o_busy      = (state_q == ST_ACTIVE);
   assign bus.o_dbg_state = state_q;

endmodule
